// File: rtl/fifo_sync_param.sv
// -----------------------------------------------------------------------------
// fifo_sync_param
//   Parametrised single-clock FIFO with occupancy count, almost-full /
//   almost-empty thresholds, one-cycle overflow/underflow pulses and an
//   optional first-word-fall-through read mode.
//
// Parameters
//   DATA_W     data width in bits
//   DEPTH      number of entries (power of two, >= 2)
//   AF_THRESH  almost_full  when count >= AF_THRESH (AF_THRESH <= DEPTH)
//   AE_THRESH  almost_empty when count <= AE_THRESH (AE_THRESH <  DEPTH)
//   FWFT       0: registered read, dout valid the cycle after rd_en
//              1: dout shows the head word combinationally while not empty
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous reset, active-high
//   wr_en / din   write request and data
//   rd_en         read request (FWFT: pop the displayed word)
//   dout          read data
//   full, empty, almost_full, almost_empty   registered status flags
//   count         occupancy 0..DEPTH
//   overflow      1-cycle pulse: write attempted while full
//   underflow     1-cycle pulse: read attempted while empty
// -----------------------------------------------------------------------------
module fifo_sync_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [DATA_W-1:0]         din,
    input  logic                      rd_en,
    output logic [DATA_W-1:0]         dout,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    // Storage: never reset, contents behind the pointers are simply stale.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          full_q,   full_d;
    logic          empty_q,  empty_d;
    logic          af_q,     af_d;
    logic          ae_q,     ae_d;
    logic          ovf_q,    ovf_d;
    logic          unf_q,    unf_d;

    logic          wr_acc;
    logic          rd_acc;

    // Acceptance is decided from the registered flags only, so a full FIFO
    // rejects a write even when a read frees a slot on the same edge, and
    // an empty FIFO rejects a read even when a write arrives on that edge.
    always_comb begin
        wr_acc   = wr_en && !full_q;
        rd_acc   = rd_en && !empty_q;

        wr_ptr_d = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;

        count_d  = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Flags are derived from the next count and registered alongside it,
        // so they change on the same edge as the pointers and never glitch.
        full_d   = (count_d == DEPTH_C);
        empty_d  = (count_d == '0);
        af_d     = (count_d >= AF_C);
        ae_d     = (count_d <= AE_C);

        ovf_d    = wr_en && full_q;
        unf_d    = rd_en && empty_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_acc) begin
            mem[wr_ptr_q] <= din;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is visible as soon as empty drops; forced to zero
            // while empty so stale memory never leaks onto dout.
            assign dout = empty_q ? '0 : mem[rd_ptr_q];
        end else begin : g_std
            logic [DATA_W-1:0] dout_q, dout_d;

            // dout only moves on an accepted read; rejected reads hold it.
            always_comb begin
                dout_d = dout_q;
                if (rd_acc) begin
                    dout_d = mem[rd_ptr_q];
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    dout_q <= '0;
                end else begin
                    dout_q <= dout_d;
                end
            end

            assign dout = dout_q;
        end
    endgenerate

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// -----------------------------------------------------------------------------
// tb_fifo_sync_param
//   Self-checking bench for fifo_sync_param. Two instances: one in standard
//   registered-read mode, one in first-word-fall-through mode. Stimulus pushes
//   the expected read word into a scoreboard queue; independent monitors pop
//   and compare when the read data is due.
// -----------------------------------------------------------------------------
module tb_fifo_sync_param;

    logic       clk;
    logic       reset;

    // standard-read instance
    logic       wr_en, rd_en;
    logic [7:0] din, dout;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;

    // FWFT instance
    logic       f_wr_en, f_rd_en;
    logic [7:0] f_din, f_dout;
    logic       f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
    logic [4:0] f_count;

    int         n_cmp;
    int         n_err;

    logic [7:0] model_q [$];
    logic [7:0] exp_q   [$];
    logic [7:0] f_exp_q [$];
    bit         rd_expect;
    bit         f_rd_expect;

    fifo_sync_param #(.DATA_W(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(dout),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    fifo_sync_param #(.DATA_W(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)) dut_fw (
        .clk(clk), .reset(reset), .wr_en(f_wr_en), .din(f_din), .rd_en(f_rd_en), .dout(f_dout),
        .full(f_full), .empty(f_empty), .almost_full(f_almost_full), .almost_empty(f_almost_empty),
        .count(f_count), .overflow(f_overflow), .underflow(f_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock of traffic on the standard instance. The queue model decides
    // acceptance from the pre-edge occupancy and queues the expected read word.
    task automatic cyc(input bit w, input logic [7:0] d, input bit r);
        bit wa, ra;
        wa = w && (model_q.size() < 16);
        ra = r && (model_q.size() > 0);
        wr_en = w; din = d; rd_en = r; rd_expect = ra;
        if (ra) exp_q.push_back(model_q.pop_front());
        if (wa) model_q.push_back(d);
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0; rd_expect = 1'b0;
    endtask

    // Standard-mode monitor: read data is due just after the accepting edge.
    always @(posedge clk) begin
        bit pend;
        logic [7:0] e;
        pend = rd_expect;
        #1;
        if (pend) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_underrun: got dout %0h required a queued word", dout);
            end else begin
                e = exp_q.pop_front();
                if (dout !== e) begin
                    n_err++;
                    $display("FAIL rd_data: got %0h expected %0h", dout, e);
                end else begin
                    $display("read dout=%0h ok", dout);
                end
            end
        end
    end

    // FWFT monitor: the word being popped is on dout during the rd_en cycle.
    always @(negedge clk) begin
        logic [7:0] e;
        if (f_rd_expect) begin
            n_cmp++;
            if (f_exp_q.size() == 0) begin
                n_err++;
                $display("FAIL fw_sb_underrun: got dout %0h required a queued word", f_dout);
            end else begin
                e = f_exp_q.pop_front();
                if (f_dout !== e) begin
                    n_err++;
                    $display("FAIL fw_rd_data: got %0h expected %0h", f_dout, e);
                end else begin
                    $display("fwft pop dout=%0h ok", f_dout);
                end
            end
        end
    end

    initial begin
        n_cmp = 0; n_err = 0;
        reset = 1'b1;
        wr_en = 1'b0; rd_en = 1'b0; din = '0; rd_expect = 1'b0;
        f_wr_en = 1'b0; f_rd_en = 1'b0; f_din = '0; f_rd_expect = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // ---- 1: random traffic, then 2-cycle reset ----
        for (int i = 0; i < 24; i++) begin
            wr_en = 1'($urandom_range(0, 1));
            rd_en = 1'($urandom_range(0, 1));
            din   = 8'($urandom);
            @(posedge clk); #1;
        end
        wr_en = 1'b0; rd_en = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_aempty", almost_empty, 1);
        chk("rst_full", full, 0);
        chk("rst_afull", almost_full, 0);
        chk("rst_dout", dout, 8'h00);
        chk("rst_ovf", overflow, 0);
        chk("rst_unf", underflow, 0);
        reset = 1'b0;
        model_q.delete();
        exp_q.delete();
        @(posedge clk); #1;
        chk("rst_hold_ovf", overflow, 0);
        chk("rst_hold_unf", underflow, 0);

        // ---- 2: fill with FF..F0, then rejected 11 ----
        for (int k = 1; k <= 16; k++) begin
            cyc(1'b1, 8'hFF - 8'(k - 1), 1'b0);
            chk($sformatf("fill_count_%0d", k), count, k);
            chk($sformatf("fill_afull_%0d", k), almost_full, (k >= 14));
            chk($sformatf("fill_full_%0d", k), full, (k == 16));
        end
        cyc(1'b1, 8'h11, 1'b0);
        chk("ovf_pulse", overflow, 1);
        chk("ovf_count", count, 16);
        chk("ovf_full", full, 1);
        cyc(1'b0, 8'h00, 1'b0);
        chk("ovf_clear", overflow, 0);

        // ---- 3: drain FF..F0, then underflow ----
        for (int k = 1; k <= 16; k++) begin
            cyc(1'b0, 8'h00, 1'b1);
            chk($sformatf("drain_aempty_%0d", k), almost_empty, ((16 - k) <= 2));
        end
        chk("drain_empty", empty, 1);
        chk("drain_count", count, 0);
        cyc(1'b0, 8'h00, 1'b1);
        chk("unf_pulse", underflow, 1);
        chk("unf_dout_hold", dout, 8'hF0);
        cyc(1'b0, 8'h00, 1'b0);
        chk("unf_clear", underflow, 0);
        chk("unf_dout_hold2", dout, 8'hF0);

        // ---- 4: simultaneous read/write at count 8 and at full ----
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'h01 + 8'(i), 1'b0);
        chk("mid_count", count, 8);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 8'h09 + 8'(i), 1'b1);
            chk($sformatf("rw_count_%0d", i), count, 8);
        end
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'h0D + 8'(i), 1'b0);
        chk("rw_full", full, 1);
        cyc(1'b1, 8'h55, 1'b1);
        chk("rwfull_ovf", overflow, 1);
        chk("rwfull_count", count, 15);
        chk("rwfull_full", full, 0);
        for (int i = 0; i < 15; i++) cyc(1'b0, 8'h00, 1'b1);
        chk("rw_drain_empty", empty, 1);

        // ---- 5: three rounds of write 10 / read 10 across the wrap ----
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 10; i++) cyc(1'b1, 8'h30 + 8'(r * 10 + i), 1'b0);
            chk($sformatf("round_count_%0d", r), count, 10);
            for (int i = 0; i < 10; i++) cyc(1'b0, 8'h00, 1'b1);
        end
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'h90 + 8'(i), 1'b0);
        chk("pre_rst_count", count, 5);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_q.delete();
        chk("midrst_empty", empty, 1);
        chk("midrst_count", count, 0);
        chk("midrst_dout", dout, 8'h00);
        cyc(1'b1, 8'h77, 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
        chk("post_rst_count", count, 0);

        // ---- 6: FWFT instance ----
        chk("fw_init_empty", f_empty, 1);
        chk("fw_init_dout", f_dout, 8'h00);
        f_wr_en = 1'b1; f_din = 8'hA5;
        @(posedge clk); #1;
        f_wr_en = 1'b0;
        chk("fw_wr_empty", f_empty, 0);
        chk("fw_wr_dout", f_dout, 8'hA5);
        f_wr_en = 1'b1; f_din = 8'h3C;
        @(posedge clk); #1;
        f_wr_en = 1'b0;
        chk("fw_head_hold", f_dout, 8'hA5);
        chk("fw_count2", f_count, 2);
        f_rd_en = 1'b1; f_rd_expect = 1'b1; f_exp_q.push_back(8'hA5);
        @(posedge clk); #1;
        f_rd_en = 1'b0; f_rd_expect = 1'b0;
        chk("fw_pop1_dout", f_dout, 8'h3C);
        chk("fw_pop1_count", f_count, 1);
        f_rd_en = 1'b1; f_rd_expect = 1'b1; f_exp_q.push_back(8'h3C);
        @(posedge clk); #1;
        f_rd_en = 1'b0; f_rd_expect = 1'b0;
        chk("fw_pop2_empty", f_empty, 1);
        chk("fw_pop2_dout", f_dout, 8'h00);

        // let monitors finish, then confirm every queued word was checked
        repeat (2) @(posedge clk);
        #2;
        chk("sb_leftover", exp_q.size(), 0);
        chk("fw_sb_leftover", f_exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
